// File: rtl/mod_add_pkg.sv
// Shared definitions for the modular-add arbiter slice.
// Contents: default widths, requester-id width helper, round-robin index helper.
package mod_add_pkg;

  localparam int unsigned DEF_BITWIDTH = 32;
  localparam int unsigned DEF_NUM_REQ  = 4;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Index visited 'step' positions after 'last' in a ring of 'n' requesters.
  function automatic int unsigned rr_index(input int unsigned last,
                                           input int unsigned step,
                                           input int unsigned n);
    return (last + step) % n;
  endfunction

endpackage

// File: rtl/mod_add_arbiter_if.sv
// Request/response bus for mod_add_arbiter.
// master: requesters + response consumer (drive requests, modulus load, iRspReady).
// slave : the arbiter (drives oReqReady and the registered response).
interface mod_add_arbiter_if
  import mod_add_pkg::*;
#(
  parameter int unsigned BITWIDTH = DEF_BITWIDTH,
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ
);

  localparam int unsigned IDW = id_width(NUM_REQ);

  logic                        iModLoad;
  logic [BITWIDTH-1:0]         iModIn;
  logic [NUM_REQ-1:0]          iReqValid;
  logic [NUM_REQ*BITWIDTH-1:0] iReqData0;
  logic [NUM_REQ*BITWIDTH-1:0] iReqData1;
  logic [NUM_REQ-1:0]          oReqReady;
  logic                        oRspValid;
  logic                        iRspReady;
  logic [BITWIDTH-1:0]         oRspData;
  logic [IDW-1:0]              oRspId;
  logic                        oRspErr;

  modport master (
    output iModLoad, iModIn, iReqValid, iReqData0, iReqData1, iRspReady,
    input  oReqReady, oRspValid, oRspData, oRspId, oRspErr
  );

  modport slave (
    input  iModLoad, iModIn, iReqValid, iReqData0, iReqData1, iRspReady,
    output oReqReady, oRspValid, oRspData, oRspId, oRspErr
  );

endinterface

// File: rtl/mod_add_arbiter_mod_adder.sv
// mod_adder: combinational (a + b) mod m for operands already below m.
// Ports: a_i, b_i operands; m_i modulus; sum_c_o result (combinational).
// The sum is kept one bit wider so the carry out participates in the compare.
// m_i == 0 yields the plain truncated sum, since no sum is below zero.
module mod_adder
  import mod_add_pkg::*;
#(
  parameter int unsigned BITWIDTH = DEF_BITWIDTH
) (
  input  logic [BITWIDTH-1:0] a_i,
  input  logic [BITWIDTH-1:0] b_i,
  input  logic [BITWIDTH-1:0] m_i,
  output logic [BITWIDTH-1:0] sum_c_o
);

  logic [BITWIDTH:0] sum_w;
  logic [BITWIDTH:0] diff_w;

  always_comb begin
    sum_w   = {1'b0, a_i} + {1'b0, b_i};
    diff_w  = sum_w - {1'b0, m_i};
    sum_c_o = (sum_w < {1'b0, m_i}) ? sum_w[BITWIDTH-1:0] : diff_w[BITWIDTH-1:0];
  end

endmodule

// File: rtl/mod_add_arbiter.sv
// mod_add_arbiter: round-robin arbiter sharing one modular adder among
// NUM_REQ requesters, with a single-entry registered response stage.
// Ports: iClk, iRst (async, active-high); bus (slave modport) carrying
//   modulus load, packed request operands/valids, one-hot oReqReady grant,
//   and the registered response oRspValid/oRspData/oRspId/oRspErr.
// Optional: define MOD_ADD_ARB_RANGE_CHECK_EN to flag operands >= modulus
//   on oRspErr; otherwise oRspErr is tied low.
module mod_add_arbiter
  import mod_add_pkg::*;
#(
  parameter int unsigned BITWIDTH = DEF_BITWIDTH,
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ
) (
  input logic              iClk,
  input logic              iRst,
  mod_add_arbiter_if.slave bus
);

  localparam int unsigned IDW = id_width(NUM_REQ);

  logic                rsp_valid_q, rsp_valid_d;
  logic [BITWIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic [IDW-1:0]      rsp_id_q,    rsp_id_d;
  logic [BITWIDTH-1:0] mod_q,       mod_d;
  logic [IDW-1:0]      ptr_q,       ptr_d;

  logic                free_c;
  logic                found_c;
  logic                accept_c;
  logic [IDW-1:0]      sel_c;
  logic [IDW-1:0]      cand_c;
  logic [NUM_REQ-1:0]  grant_c;
  logic [BITWIDTH-1:0] op_a_c;
  logic [BITWIDTH-1:0] op_b_c;
  logic [BITWIDTH-1:0] sum_c;

  assign free_c = !rsp_valid_q || bus.iRspReady;

  // Round-robin pick: first valid requester after the last granted one.
  always_comb begin
    grant_c = '0;
    sel_c   = '0;
    cand_c  = '0;
    found_c = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand_c = IDW'(rr_index(32'(ptr_q), i + 1, NUM_REQ));
      if (!found_c && bus.iReqValid[cand_c]) begin
        found_c = 1'b1;
        sel_c   = cand_c;
      end
    end
    if (found_c && free_c && !iRst) begin
      grant_c[sel_c] = 1'b1;
    end
  end

  assign accept_c      = |grant_c;
  assign bus.oReqReady = grant_c;

  // Operand mux for the shared datapath.
  assign op_a_c = bus.iReqData0[32'(sel_c) * BITWIDTH +: BITWIDTH];
  assign op_b_c = bus.iReqData1[32'(sel_c) * BITWIDTH +: BITWIDTH];

  mod_adder #(
    .BITWIDTH (BITWIDTH)
  ) u_mod_adder (
    .a_i     (op_a_c),
    .b_i     (op_b_c),
    .m_i     (mod_q),
    .sum_c_o (sum_c)
  );

  // Next state: load on accept, drain on consume, otherwise hold.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    ptr_d       = ptr_q;
    mod_d       = mod_q;
    if (accept_c) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = sum_c;
      rsp_id_d    = sel_c;
      ptr_d       = sel_c;
    end else if (bus.iRspReady) begin
      rsp_valid_d = 1'b0;
    end
    if (bus.iModLoad) begin
      mod_d = bus.iModIn;
    end
  end

  // State registers; pointer resets so requester 0 is checked first.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      mod_q       <= '0;
      ptr_q       <= IDW'(NUM_REQ - 1);
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      mod_q       <= mod_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.oRspValid = rsp_valid_q;
  assign bus.oRspData  = rsp_data_q;
  assign bus.oRspId    = rsp_id_q;

`ifdef MOD_ADD_ARB_RANGE_CHECK_EN
  logic rsp_err_q, rsp_err_d;
  logic range_err_c;

  // A zero modulus means "no reduction", so it never flags an error.
  assign range_err_c = (mod_q != '0) && ((op_a_c >= mod_q) || (op_b_c >= mod_q));

  always_comb begin
    rsp_err_d = rsp_err_q;
    if (accept_c) begin
      rsp_err_d = range_err_c;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= rsp_err_d;
    end
  end

  assign bus.oRspErr = rsp_err_q;
`else
  assign bus.oRspErr = 1'b0;
`endif

endmodule

// File: tb/tb_mod_add_arbiter.sv
// Directed, table-driven bench for mod_add_arbiter (default parameters).
module tb_mod_add_arbiter;

  logic iClk;
  logic iRst;
  int   checks;
  int   errors;

  mod_add_arbiter_if bus ();

  mod_add_arbiter dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    logic         ld;
    logic [31:0]  m;
    logic [3:0]   v;
    logic [127:0] d0;
    logic [127:0] d1;
    logic         rr;
    logic [3:0]   rdy;
    logic         ov;
    logic [31:0]  od;
    logic [1:0]   oid;
    logic         oerr;
  } vec_t;

  vec_t vecs [23];

  function automatic logic [127:0] pack4(input logic [31:0] a0, input logic [31:0] a1,
                                         input logic [31:0] a2, input logic [31:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic err_exp(input logic e);
`ifdef MOD_ADD_ARB_RANGE_CHECK_EN
    return e;
`else
    return 1'b0 & e;
`endif
  endfunction

  task automatic drive(input logic ld, input logic [31:0] m, input logic [3:0] v,
                       input logic [127:0] d0, input logic [127:0] d1, input logic rr);
    bus.iModLoad  = ld;
    bus.iModIn    = m;
    bus.iReqValid = v;
    bus.iReqData0 = d0;
    bus.iReqData1 = d1;
    bus.iRspReady = rr;
  endtask

  task automatic chk_rsp(input string tag, input logic ov, input logic [31:0] od,
                         input logic [1:0] oid, input logic oerr);
    chk({tag, " valid"}, 32'(bus.oRspValid), 32'(ov));
    chk({tag, " data"},  bus.oRspData,       od);
    chk({tag, " id"},    32'(bus.oRspId),    32'(oid));
    chk({tag, " err"},   32'(bus.oRspErr),   32'(err_exp(oerr)));
  endtask

  logic [127:0] db0, db1, z;

  initial begin
    checks = 0;
    errors = 0;
    z   = '0;
    db0 = pack4(32'd10, 32'd6, 32'd7, 32'd8);
    db1 = pack4(32'd9, 32'd10, 32'd10, 32'd10);

    //          ld    m             v        d0   d1   rr    rdy      ov    od     oid   oerr
    vecs[0]  = '{1'b1, 32'd17, 4'b0000, z, z, 1'b1, 4'b0000, 1'b0, 32'd0,  2'd0, 1'b0};
    vecs[1]  = '{1'b0, 32'd0,  4'b1111, db0, db1, 1'b1, 4'b0001, 1'b1, 32'd2,  2'd0, 1'b0};
    vecs[2]  = '{1'b0, 32'd0,  4'b1111, db0, db1, 1'b1, 4'b0010, 1'b1, 32'd16, 2'd1, 1'b0};
    vecs[3]  = '{1'b0, 32'd0,  4'b1111, db0, db1, 1'b1, 4'b0100, 1'b1, 32'd0,  2'd2, 1'b0};
    vecs[4]  = '{1'b0, 32'd0,  4'b1111, db0, db1, 1'b1, 4'b1000, 1'b1, 32'd1,  2'd3, 1'b0};
    vecs[5]  = '{1'b0, 32'd0,  4'b1111, db0, db1, 1'b1, 4'b0001, 1'b1, 32'd2,  2'd0, 1'b0};
    vecs[6]  = '{1'b0, 32'd0,  4'b0000, db0, db1, 1'b1, 4'b0000, 1'b0, 32'd2,  2'd0, 1'b0};
    vecs[7]  = '{1'b0, 32'd0,  4'b1111, db0, db1, 1'b0, 4'b0010, 1'b1, 32'd16, 2'd1, 1'b0};
    for (int i = 8; i <= 12; i++)
      vecs[i] = '{1'b0, 32'd0, 4'b1111, db0, db1, 1'b0, 4'b0000, 1'b1, 32'd16, 2'd1, 1'b0};
    vecs[13] = '{1'b0, 32'd0,  4'b1111, db0, db1, 1'b1, 4'b0100, 1'b1, 32'd0,  2'd2, 1'b0};
    vecs[14] = '{1'b1, 32'd7,  4'b0000, z, z, 1'b1, 4'b0000, 1'b0, 32'd0, 2'd2, 1'b0};
    vecs[15] = '{1'b1, 32'd5,  4'b0001, pack4(32'd4, 0, 0, 0), pack4(32'd3, 0, 0, 0),
                 1'b1, 4'b0001, 1'b1, 32'd0, 2'd0, 1'b0};
    vecs[16] = '{1'b0, 32'd0,  4'b0001, pack4(32'd4, 0, 0, 0), pack4(32'd3, 0, 0, 0),
                 1'b1, 4'b0001, 1'b1, 32'd2, 2'd0, 1'b0};
    vecs[17] = '{1'b1, 32'd3,  4'b0000, z, z, 1'b0, 4'b0000, 1'b1, 32'd2, 2'd0, 1'b0};
    vecs[18] = '{1'b0, 32'd0,  4'b0000, z, z, 1'b1, 4'b0000, 1'b0, 32'd2, 2'd0, 1'b0};
    vecs[19] = '{1'b1, 32'hFFFF_FFFF, 4'b0000, z, z, 1'b1, 4'b0000, 1'b0, 32'd2, 2'd0, 1'b0};
    vecs[20] = '{1'b0, 32'd0,  4'b0100, pack4(0, 0, 32'hFFFF_FFFE, 0), pack4(0, 0, 32'hFFFF_FFFE, 0),
                 1'b1, 4'b0100, 1'b1, 32'hFFFF_FFFD, 2'd2, 1'b0};
    vecs[21] = '{1'b1, 32'd10, 4'b0000, z, z, 1'b1, 4'b0000, 1'b0, 32'hFFFF_FFFD, 2'd2, 1'b0};
    vecs[22] = '{1'b0, 32'd0,  4'b1000, pack4(0, 0, 0, 32'd12), pack4(0, 0, 0, 32'd1),
                 1'b1, 4'b1000, 1'b1, 32'd3, 2'd3, 1'b1};

    // Reset: outputs cleared and no grant even with requests pending.
    iRst = 1'b1;
    drive(1'b0, 32'd0, 4'b1111, db0, db1, 1'b1);
    repeat (2) @(posedge iClk);
    #1;
    chk("reset ready", 32'(bus.oReqReady), 32'd0);
    chk_rsp("reset", 1'b0, 32'd0, 2'd0, 1'b0);
    iRst = 1'b0;

    // Table: drive, check combinational grant, clock, check response.
    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].ld, vecs[i].m, vecs[i].v, vecs[i].d0, vecs[i].d1, vecs[i].rr);
      #1;
      chk($sformatf("v%0d ready", i), 32'(bus.oReqReady), 32'(vecs[i].rdy));
      @(posedge iClk);
      #1;
      chk_rsp($sformatf("v%0d", i), vecs[i].ov, vecs[i].od, vecs[i].oid, vecs[i].oerr);
    end

    // Accept with M=10 then hold, then reset asynchronously mid-hold.
    drive(1'b0, 32'd0, 4'b0001, pack4(32'd1, 0, 0, 0), pack4(32'd1, 0, 0, 0), 1'b1);
    #1;
    chk("pre-rst ready", 32'(bus.oReqReady), 32'd1);
    @(posedge iClk);
    #1;
    chk_rsp("pre-rst", 1'b1, 32'd2, 2'd0, 1'b0);
    drive(1'b0, 32'd0, 4'b0000, z, z, 1'b0);
    @(posedge iClk);
    #1;
    chk_rsp("hold", 1'b1, 32'd2, 2'd0, 1'b0);
    drive(1'b0, 32'd0, 4'b1111, db0, db1, 1'b1);
    #2;
    iRst = 1'b1;
    #1;
    chk_rsp("mid-rst", 1'b0, 32'd0, 2'd0, 1'b0);
    chk("mid-rst ready", 32'(bus.oReqReady), 32'd0);
    @(posedge iClk);
    #1;
    chk("rst edge ready", 32'(bus.oReqReady), 32'd0);
    chk_rsp("rst edge", 1'b0, 32'd0, 2'd0, 1'b0);
    iRst = 1'b0;
    #1;
    // Pointer back to requester 0; modulus cleared so the plain sum comes out.
    chk("post-rst ready", 32'(bus.oReqReady), 32'd1);
    @(posedge iClk);
    #1;
    chk_rsp("post-rst", 1'b1, 32'd19, 2'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_add_arbiter.md
MOD_ADD_ARBITER -- requirements
Module: mod_add_arbiter

Interface
REQ-001 Parameter BITWIDTH, default 32: operand, modulus and result width.
REQ-002 Parameter NUM_REQ, default 4: number of requesters; IDW = max(1, clog2(NUM_REQ)).
REQ-003 iClk  input  1: sole clock; all state updates on rising edge.
REQ-004 iRst  input  1: reset, asynchronous, active-high.
REQ-005 iModLoad  input  1: load iModIn into internal modulus register.
REQ-006 iModIn  input  BITWIDTH: new modulus value.
REQ-007 iReqValid  input  NUM_REQ: per-requester request valid.
REQ-008 iReqData0  input  NUM_REQ*BITWIDTH: packed operand A; requester k occupies bits [k*BITWIDTH +: BITWIDTH].
REQ-009 iReqData1  input  NUM_REQ*BITWIDTH: packed operand B, same packing.
REQ-010 oReqReady  output  NUM_REQ: one-hot grant; request k accepted when iReqValid[k] & oReqReady[k].
REQ-011 oRspValid  output  1: response valid.
REQ-012 iRspReady  input  1: downstream accepts response.
REQ-013 oRspData  output  BITWIDTH: (A + B) mod M.
REQ-014 oRspId  output  IDW: index of requester that produced oRspData.
REQ-015 oRspErr  output  1: operand-range error flag (see Configuration).

Function
REQ-016 Shall share one combinational modular adder among all requesters; at most one request accepted per cycle.
REQ-017 Arithmetic: sum formed at BITWIDTH+1 bits; result = sum if sum < M, else sum - M, truncated to BITWIDTH.
REQ-018 Output stage is a single-entry register; "free" = !oRspValid | iRspReady.
REQ-019 oReqReady shall be combinational: zero when not free; otherwise one-hot on the first valid requester in round-robin order starting at (last granted index + 1) mod NUM_REQ.
REQ-020 oReqReady shall not depend on iReqValid of non-selected requesters beyond priority selection; all-zero when no iReqValid bit set.
REQ-021 Latency: request accepted in cycle t -> oRspValid=1 with result, id in cycle t+1; sustained throughput 1/cycle while iRspReady=1.
REQ-022 While oRspValid=1 and iRspReady=0, oRspData, oRspId, oRspErr shall hold stable.
REQ-023 Response consumed and no new accept in same cycle -> oRspValid=0 next cycle.
REQ-024 Last-granted pointer updates only on an accept; NUM_REQ=1 degenerates to pass-through with pointer fixed at 0.
REQ-025 iModLoad takes effect next cycle; accept in same cycle as iModLoad uses old modulus; held response never recomputed.
REQ-026 Caller ensures iModIn >= 1; behaviour for M=0 is result = sum, no error.

Reset
REQ-027 On iRst: oRspValid=0, oRspData=0, oRspId=0, oRspErr=0, modulus register=0, last-granted pointer = NUM_REQ-1 (requester 0 highest first priority).
REQ-028 Reset asserted mid-operation discards the held response and any same-cycle accept; oReqReady forced 0 while iRst=1.

Configuration
REQ-029 Macro MOD_ADD_ARB_RANGE_CHECK_EN defined: oRspErr registered with response, set when accepted A >= M or B >= M; result still computed per REQ-017.
REQ-030 Macro undefined: oRspErr tied 0, no comparators synthesized.

Structure
REQ-031 Shared package mod_add_pkg: default BITWIDTH, default NUM_REQ, IDW computation function, round-robin next-index function.
REQ-032 One sub-module: existing mod_adder instantiated once for the shared datapath; arbitration and output register in this module.

Verification
REQ-033 Reset then M=17 loaded; req0 A=10 B=9 -> next cycle oRspData=2, oRspId=0, oRspErr=0.
REQ-034 All four valid continuously, iRspReady=1 -> grants 0,1,2,3,0 on consecutive cycles, one response per cycle.
REQ-035 iRspReady=0 for 5 cycles with response held -> oReqReady=0, oRspData stable; release -> next grant follows rotation.
REQ-036 BITWIDTH=32, M=0xFFFFFFFF, A=B=0xFFFFFFFE -> oRspData=0xFFFFFFFD (carry bit exercised).
REQ-037 iModLoad M=5 same cycle as accept A=4 B=3 with old M=7 -> oRspData=0; following A=4 B=3 -> 2.
REQ-038 With MOD_ADD_ARB_RANGE_CHECK_EN, M=10, A=12 B=1 -> oRspErr=1, oRspData=3; without macro oRspErr=0; iRst mid-hold -> oRspValid=0 immediately.
